// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns a debounced active-low key level into one-cycle
// short / double / long / auto-repeat pulses with a shared cycle counter.
module key_event_decoder #(
    parameter int               CNT_W      = 24,
    parameter logic [CNT_W-1:0] LONG_CNT   = 24'd5_000_000,
    parameter logic [CNT_W-1:0] REPEAT_CNT = 24'd1_000_000,
    parameter logic [CNT_W-1:0] DCLICK_CNT = 24'd2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {IDLE, PRESS, LONG, WAIT2, PRESS2} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - 1'b1;
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1'b1;
    localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_CNT - 1'b1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_long_hit;
    logic             w_rep_hit;
    logic             w_dclick_hit;

    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_long_hit   = (r_cnt == LONG_LAST);
    assign w_rep_hit    = (r_cnt == REPEAT_LAST);
    assign w_dclick_hit = (r_cnt == DCLICK_LAST);

    // Release is tested before every threshold so it always wins a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            r_cnt        <= w_cnt_inc;
            case (r_state)
                IDLE: begin
                    if (!key_in) begin
                        r_state <= PRESS;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                PRESS: begin
                    if (key_in) begin
                        r_state <= WAIT2;
                        r_cnt   <= '0;
                    end else if (w_long_hit) begin
                        r_state    <= LONG;
                        r_cnt      <= '0;
                        long_pulse <= 1'b1;
                    end
                end
                LONG: begin
                    if (key_in) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (w_rep_hit) begin
                        r_cnt        <= '0;
                        repeat_pulse <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (!key_in) begin
                        r_state <= PRESS2;
                        r_cnt   <= '0;
                    end else if (w_dclick_hit) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        short_pulse <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                PRESS2: begin
                    if (key_in) begin
                        r_state      <= IDLE;
                        r_cnt        <= '0;
                        double_pulse <= 1'b1;
                        busy         <= 1'b0;
                    end else if (w_long_hit) begin
                        // Pending first click is reported together with the long press.
                        r_state     <= LONG;
                        r_cnt       <= '0;
                        short_pulse <= 1'b1;
                        long_pulse  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
